// File: rtl/wavetable_osc_if.sv
// Bus bundle for the wavetable oscillator: the registered-read sine ROM port
// and the valid/ready sample stream toward the mixer/DAC path.
interface wavetable_osc_if;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output rom_en,
    output rom_addr,
    input  rom_data,
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  rom_en,
    input  rom_addr,
    output rom_data,
    input  sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/wavetable_osc.sv
// Wavetable oscillator: steps a 24-bit phase accumulator on each accepted
// audio tick, reads one packed byte from the sine ROM, re-centres it to
// signed, scales it by gain and offers it on a valid/ready stream. One tick
// can be held pending while a sample is in flight; a further one is dropped
// and flagged on overrun.
module wavetable_osc (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   tick,
  input  logic                   phase_clr,
  input  logic [23:0]            ftw,
  input  logic [7:0]             gain,
  output logic                   overrun,
  wavetable_osc_if.master        bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t             state_r;
  logic [23:0]        phase_r;
  logic               idx_lsb_r;
  logic               pending_r;
  logic               rom_en_r;
  logic [7:0]         rom_addr_r;
  logic [15:0]        sample_r;
  logic               sample_valid_r;
  logic               overrun_r;

  logic               tick_s;
  logic               start_s;
  logic [8:0]         cur_idx_s;
  logic [7:0]         byte_s;
  logic signed [15:0] s_ext_s;
  logic signed [15:0] g_ext_s;
  logic signed [15:0] prod_s;

  // ROM stores offset-binary bytes; flipping the MSB re-centres them on zero.
  function automatic logic [7:0] offset_to_signed(input logic [7:0] b);
    return {~b[7], b[6:0]};
  endfunction

  // Decide whether a sample sequence starts at this edge (new tick or pending).
  always_comb begin
    tick_s    = tick & enable;
    cur_idx_s = phase_r[23:15];
    start_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_r || tick_s) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end
      ST_OUT: begin
        if (bus.sample_ready && pending_r) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  // Pick the addressed byte from the ROM word and scale it by the gain.
  always_comb begin
    if (idx_lsb_r) begin
      byte_s = bus.rom_data[15:8];
    end else begin
      byte_s = bus.rom_data[7:0];
    end
    s_ext_s = {{8{offset_to_signed(byte_s)[7]}}, offset_to_signed(byte_s)};
    g_ext_s = {8'd0, gain};
    prod_s  = s_ext_s * g_ext_s;
  end

  // Phase accumulator; a clear wins over a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 24'd0;
    end else if (phase_clr) begin
      phase_r <= 24'd0;
    end else if (start_s) begin
      phase_r <= phase_r + ftw;
    end else begin
      phase_r <= phase_r;
    end
  end

  // Sequencer IDLE->READ->WAIT->OUT with the pending-tick bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      idx_lsb_r      <= 1'b0;
      pending_r      <= 1'b0;
      rom_en_r       <= 1'b0;
      rom_addr_r     <= 8'd0;
      sample_r       <= 16'd0;
      sample_valid_r <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      overrun_r <= (state_r != ST_IDLE) && tick_s && pending_r;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r    <= ST_READ;
            rom_en_r   <= 1'b1;
            rom_addr_r <= cur_idx_s[8:1];
            idx_lsb_r  <= cur_idx_s[0];
            // Servicing a pending tick leaves room for a fresh one to pend.
            pending_r  <= pending_r & tick_s;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_READ: begin
          rom_en_r  <= 1'b0;
          state_r   <= ST_WAIT;
          pending_r <= pending_r | tick_s;
        end
        ST_WAIT: begin
          sample_r       <= prod_s;
          sample_valid_r <= 1'b1;
          state_r        <= ST_OUT;
          pending_r      <= pending_r | tick_s;
        end
        ST_OUT: begin
          if (bus.sample_ready) begin
            sample_valid_r <= 1'b0;
            if (pending_r) begin
              state_r    <= ST_READ;
              rom_en_r   <= 1'b1;
              rom_addr_r <= cur_idx_s[8:1];
              idx_lsb_r  <= cur_idx_s[0];
              pending_r  <= 1'b0;
            end else begin
              state_r    <= ST_IDLE;
              pending_r  <= tick_s;
            end
          end else begin
            pending_r <= pending_r | tick_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rom_en       = rom_en_r;
  assign bus.rom_addr     = rom_addr_r;
  assign bus.sample       = sample_r;
  assign bus.sample_valid = sample_valid_r;
  assign overrun          = overrun_r;

endmodule

// File: tb/tb_wavetable_osc.sv
// Self-checking bench for wavetable_osc: a sine ROM model, a request-level
// reference model and a per-cycle comparator, plus directed scenarios with
// hand-computed literal expectations.
module tb_wavetable_osc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tick = 1'b0;
  logic        phase_clr = 1'b0;
  logic [23:0] ftw = 24'd0;
  logic [7:0]  gain = 8'd0;
  logic        overrun;

  wavetable_osc_if bus ();

  wavetable_osc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .tick      (tick),
    .phase_clr (phase_clr),
    .ftw       (ftw),
    .gain      (gain),
    .overrun   (overrun),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ovr_seen = 0;
  int hs_seen = 0;

  logic [15:0] rom [256];

  // Reference model state (request level)
  logic [23:0] m_phase = 24'd0;
  bit          m_busy = 1'b0;
  bit          m_pend = 1'b0;
  int          ecnt = 0;
  int          m_start = -10;
  int          m_ovr_edge = -1;
  logic [7:0]  m_addr = 8'd0;
  logic [15:0] m_samp = 16'd0;

  logic [7:0]  a2 [4] = '{8'd0, 8'd64, 8'd128, 8'd192};
  logic [15:0] s2 [4] = '{16'hFFFF, 16'h007E, 16'hFFFF, 16'hFF80};
  logic [7:0]  a3 [3] = '{8'd0, 8'd255, 8'd255};
  logic [15:0] s3 [3] = '{16'hFFFF, 16'hFFFD, 16'hFFFB};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sine_byte(input int k);
    real x;
    x = 127.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 512.0) + 1.0e-9;
    return int'($floor(x));
  endfunction

  // ROM: registered read, data valid the cycle after rom_en
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  // Reference model: decides per edge which requests start and what they yield
  initial begin
    bit tk, hs, old, st;
    logic [8:0] idx;
    logic [7:0] b;
    int s;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 24'd0; m_busy = 1'b0; m_pend = 1'b0;
        m_addr = 8'd0; m_ovr_edge = -1; m_start = -10;
      end else begin
        ecnt++;
        tk  = tick && enable;
        old = m_pend;
        st  = 1'b0;
        hs  = m_busy && (ecnt - 1 >= m_start + 2) && bus.sample_ready;
        if (m_busy && tk && old) m_ovr_edge = ecnt;
        if (!m_busy) begin
          st = old || tk;
          m_pend = old && tk;
        end else if (hs) begin
          m_busy = 1'b0;
          st = old;
          m_pend = old ? 1'b0 : tk;
        end else begin
          m_pend = old || tk;
        end
        if (st) begin
          idx    = m_phase[23:15];
          m_addr = idx[8:1];
          b      = idx[0] ? rom[m_addr][15:8] : rom[m_addr][7:0];
          s      = (int'(b) - 128) * int'(gain);
          m_samp = 16'(s);
          m_busy = 1'b1;
          m_start = ecnt;
        end
        if (phase_clr) m_phase = 24'd0;
        else if (st) m_phase = m_phase + ftw;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rom_en", 32'(bus.rom_en), 32'd0);
        chk("rst_valid", 32'(bus.sample_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_sample", 32'(bus.sample), 32'd0);
      end else begin
        ev = m_busy && (ecnt >= m_start + 2);
        chk("rom_en", 32'(bus.rom_en), 32'(m_busy && (ecnt == m_start)));
        chk("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
        chk("sample_valid", 32'(bus.sample_valid), 32'(ev));
        if (ev) chk("sample", 32'(bus.sample), 32'(m_samp));
        chk("overrun", 32'(overrun), 32'(ecnt == m_ovr_edge));
        if (overrun) ovr_seen++;
      end
    end
  end

  // Handshake counter, sampled at the active edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && bus.sample_valid && bus.sample_ready) hs_seen++;
    end
  end

  task automatic tick1();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic clr1();
    @(negedge clk); phase_clr = 1'b1;
    @(negedge clk); phase_clr = 1'b0;
  endtask

  initial begin
    int hs0;
    for (int w = 0; w < 256; w++) begin
      rom[w] = {8'(sine_byte(2 * w + 1)), 8'(sine_byte(2 * w))};
    end
    chk("rom_w0", 32'(rom[0]), 32'h807F);
    chk("rom_w64", 32'(rom[64]), 32'hFDFE);
    chk("rom_w128", 32'(rom[128]), 32'h7D7F);
    chk("rom_w192", 32'(rom[192]), 32'h0000);
    chk("rom_w255", 32'(rom[255]), 32'h7D7B);

    bus.sample_ready = 1'b1;
    enable = 1'b1;
    #1;
    chk("reset_rom_en", 32'(bus.rom_en), 32'd0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("reset_valid", 32'(bus.sample_valid), 32'd0);
    chk("reset_sample", 32'(bus.sample), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic read, full gain
    gain = 8'd255; ftw = 24'h008000;
    tick1();
    chk("t1_rom_en", 32'(bus.rom_en), 32'd1);
    chk("t1_addr", 32'(bus.rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    chk("t1_valid", 32'(bus.sample_valid), 32'd1);
    chk("t1_sample", 32'(bus.sample), 32'hFF01);
    repeat (3) @(negedge clk);
    tick1();
    chk("t1b_addr", 32'(bus.rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    chk("t1b_sample", 32'(bus.sample), 32'h0000);
    repeat (3) @(negedge clk);

    // Quarter-period steps
    clr1();
    gain = 8'd1; ftw = 24'h400000;
    for (int i = 0; i < 4; i++) begin
      tick1();
      chk("t2_addr", 32'(bus.rom_addr), 32'(a2[i]));
      repeat (2) @(negedge clk);
      chk("t2_sample", 32'(bus.sample), 32'(s2[i]));
      repeat (3) @(negedge clk);
    end

    // Phase wrap through the top of the table
    clr1();
    ftw = 24'hFF8000;
    for (int i = 0; i < 3; i++) begin
      tick1();
      chk("t3_addr", 32'(bus.rom_addr), 32'(a3[i]));
      repeat (2) @(negedge clk);
      chk("t3_sample", 32'(bus.sample), 32'(s3[i]));
      repeat (3) @(negedge clk);
    end

    // Backpressure: pend one tick, drop the next
    clr1();
    ftw = 24'h400000;
    bus.sample_ready = 1'b0;
    hs0 = hs_seen;
    tick1();                      // T
    repeat (2) @(negedge clk);
    tick1();                      // T+4
    tick1();                      // T+6
    repeat (5) @(negedge clk);
    chk("t4_hold_valid", 32'(bus.sample_valid), 32'd1);
    chk("t4_hold_sample", 32'(bus.sample), 32'hFFFF);
    bus.sample_ready = 1'b1;
    @(negedge clk);
    chk("t4_gap_valid", 32'(bus.sample_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("t4_s2_valid", 32'(bus.sample_valid), 32'd1);
    chk("t4_s2_sample", 32'(bus.sample), 32'h007E);
    repeat (6) @(negedge clk);
    chk("t4_overruns", 32'(ovr_seen), 32'd1);
    chk("t4_handshakes", 32'(hs_seen - hs0), 32'd2);

    // Disabled ticks are ignored; phase holds
    enable = 1'b0;
    tick1();
    repeat (2) @(negedge clk);
    tick1();
    repeat (4) @(negedge clk);
    enable = 1'b1;
    tick1();
    chk("t5_addr", 32'(bus.rom_addr), 32'd128);
    repeat (2) @(negedge clk);
    chk("t5_sample", 32'(bus.sample), 32'hFFFF);
    chk("t5_overruns", 32'(ovr_seen), 32'd1);
    repeat (3) @(negedge clk);

    // Asynchronous reset while the ROM data is being consumed
    ftw = 24'h123456;
    tick1();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rom_en", 32'(bus.rom_en), 32'd0);
    chk("t6_valid", 32'(bus.sample_valid), 32'd0);
    chk("t6_sample", 32'(bus.sample), 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick1();
    chk("t6_rom_en_after", 32'(bus.rom_en), 32'd1);
    chk("t6_addr_after", 32'(bus.rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_sample_after", 32'(bus.sample), 32'hFFFF);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
